// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan driver.
// Pattern bit order is a..g with seg[6]=a and seg[0]=g, active-high.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] code_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host/display bundle for seg7_scan_driver.
// With SEG7_SCAN_DP_EN defined the bundle also carries the decimal points.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    blank_lz;
  seg_t                    seg;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;
`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    dp;

  modport master (output load, digits_in, blank_lz, dp_in,
                  input  seg, digit_sel, frame_done, dp);
  modport slave  (input  load, digits_in, blank_lz, dp_in,
                  output seg, digit_sel, frame_done, dp);
`else
  modport master (output load, digits_in, blank_lz,
                  input  seg, digit_sel, frame_done);
  modport slave  (input  load, digits_in, blank_lz,
                  output seg, digit_sel, frame_done);
`endif

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit code to 7-segment pattern decoder.
// Codes 10-15 decode to letters only when hex_mode is set, otherwise blank.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  code_t code,
  input  logic  hex_mode,
  output seg_t  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = hex_mode ? SEG_A : SEG_BLANK;
      4'd11:   seg = hex_mode ? SEG_B : SEG_BLANK;
      4'd12:   seg = hex_mode ? SEG_C : SEG_BLANK;
      4'd13:   seg = hex_mode ? SEG_D : SEG_BLANK;
      4'd14:   seg = hex_mode ? SEG_E : SEG_BLANK;
      default: seg = hex_mode ? SEG_F : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with frame-synchronous double buffering.
// Optional decimal points are enabled with the SEG7_SCAN_DP_EN macro.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int HEX_MODE         = 0,
  parameter int DIGIT_ACTIVE_LOW = 0
)(
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = (DIGIT_ACTIVE_LOW != 0) ?
                                               {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]      cnt_reg;
  logic [IDX_W-1:0]      index_reg;
  logic [DW-1:0]         shadow_reg;
  logic [DW-1:0]         active_reg;
  logic                  pending_reg;
  seg_t                  seg_reg;
  logic [NUM_DIGITS-1:0] sel_reg;
  logic                  frame_done_reg;

  logic                  tick;
  logic                  wrap;
  logic [IDX_W-1:0]      index_next;
  logic [DW-1:0]         active_next;
  code_t                 digit_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_from;
  code_t                 sel_code;
  seg_t                  dec_seg;
  seg_t                  seg_next;
  logic [NUM_DIGITS-1:0] sel_next;
  logic                  blank_now;

  assign tick       = (cnt_reg == CNT_MAX);
  assign wrap       = tick && (index_reg == IDX_MAX);
  assign index_next = (index_reg == IDX_MAX) ? '0 : index_reg + IDX_W'(1);

  // A load in the wrap cycle bypasses the shadow so it lands in the frame starting now.
  assign active_next = !wrap       ? active_reg :
                       bus.load    ? bus.digits_in :
                       pending_reg ? shadow_reg : active_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
      assign digit_code[gi] = active_next[4*gi +: 4];
    end
  endgenerate

  // zero_from[k]: digit k and every more significant digit are zero.
  always_comb begin
    logic run;
    run = 1'b1;
    zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run = run && (digit_code[k] == 4'd0);
      zero_from[k] = run;
    end
  end

  assign sel_code  = digit_code[index_next];
  assign blank_now = bus.blank_lz && (index_next != '0) && zero_from[index_next];
  assign seg_next  = blank_now ? SEG_BLANK : dec_seg;
  assign sel_next  = (NUM_DIGITS'(1) << index_next) ^ SEL_IDLE;

  seg7_hex_decoder u_decoder (
    .code     (sel_code),
    .hex_mode (HEX_MODE != 0),
    .seg      (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      index_reg      <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      pending_reg    <= 1'b0;
      seg_reg        <= SEG_BLANK;
      sel_reg        <= SEL_IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= tick ? '0 : cnt_reg + CNT_W'(1);
      active_reg     <= active_next;
      frame_done_reg <= wrap;
      if (bus.load) shadow_reg <= bus.digits_in;
      if (wrap)          pending_reg <= 1'b0;
      else if (bus.load) pending_reg <= 1'b1;
      // Outputs are computed from post-tick index/content so they change with the index.
      if (tick) begin
        index_reg <= index_next;
        seg_reg   <= seg_next;
        sel_reg   <= sel_next;
      end
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.digit_sel  = sel_reg;
  assign bus.frame_done = frame_done_reg;

`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_reg;
  logic [NUM_DIGITS-1:0] dp_active_reg;
  logic [NUM_DIGITS-1:0] dp_active_next;
  logic                  dp_reg;

  assign dp_active_next = !wrap       ? dp_active_reg :
                          bus.load    ? bus.dp_in :
                          pending_reg ? dp_shadow_reg : dp_active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_shadow_reg <= '0;
      dp_active_reg <= '0;
      dp_reg        <= 1'b0;
    end else begin
      dp_active_reg <= dp_active_next;
      if (bus.load) dp_shadow_reg <= bus.dp_in;
      if (tick)     dp_reg        <= dp_active_next[index_next];
    end
  end

  assign bus.dp = dp_reg;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: decimal/hex instance pair with 4 digits and a 4-cycle slot.
// Exercises reset, buffering, blanking, hex decode, active-low select and (if SEG7_SCAN_DP_EN) dp.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_a ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_b ();

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(0), .DIGIT_ACTIVE_LOW(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1), .DIGIT_ACTIVE_LOW(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] digits, input logic [3:0] dps);
    bus_a.load      = ld;
    bus_b.load      = ld;
    bus_a.digits_in = digits;
    bus_b.digits_in = digits;
`ifdef SEG7_SCAN_DP_EN
    bus_a.dp_in     = dps;
    bus_b.dp_in     = dps;
`else
    if (dps != 4'd0) $display("note: dp_in=%b ignored in this build", dps);
`endif
  endtask

  task automatic load_pulse(input logic [15:0] digits, input logic [3:0] dps);
    $display("load digits=%h dp=%b at t=%0t", digits, dps, $time);
    drive(1'b1, digits, dps);
    step();
    drive(1'b0, 16'h0000, 4'b0000);
  endtask

  task automatic set_blank(input logic b);
    bus_a.blank_lz = b;
    bus_b.blank_lz = b;
  endtask

  // Steps until dut_a selects digit d (bounded), then checks the select.
  task automatic wait_digit(input int d, input string tag);
    logic [3:0] target;
    target = 4'b0001 << d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_a.digit_sel == target) break;
    end
    chk(tag, 32'(bus_a.digit_sel), 32'(target));
  endtask

  task automatic wait_fd(input string tag, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (bus_a.frame_done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    chk(tag, 32'(bus_a.frame_done), 32'd1);
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    drive(1'b0, 16'h0000, 4'b0000);
    set_blank(1'b0);
    #2 rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    chk("rst_seg",     32'(bus_a.seg), 32'h00);
    chk("rst_sel_a",   32'(bus_a.digit_sel), 32'h0);
    chk("rst_sel_b",   32'(bus_b.digit_sel), 32'hF);
    chk("rst_fd",      32'(bus_a.frame_done), 32'd0);
    step(); step(); step();
    chk("no_tick_yet", 32'(bus_a.digit_sel), 32'h0);
    step();
    chk("first_tick_sel", 32'(bus_a.digit_sel), 32'b0010);
    chk("first_tick_seg", 32'(bus_a.seg), 32'b1111110);

    // Basic frame content and frame_done cadence.
    load_pulse(16'h1234, 4'b0000);
    wait_fd("fd_1234", n);
    chk("d0_1234", 32'(bus_a.seg), 32'b0110011);
    chk("d0_sel",  32'(bus_a.digit_sel), 32'b0001);
    step();
    chk("fd_pulse_one", 32'(bus_a.frame_done), 32'd0);
    wait_digit(1, "sel_d1");
    chk("d1_1234", 32'(bus_a.seg), 32'b1111001);
    wait_digit(2, "sel_d2");
    chk("d2_1234", 32'(bus_a.seg), 32'b1101101);
    wait_digit(3, "sel_d3");
    chk("d3_1234", 32'(bus_a.seg), 32'b0110000);
    wait_fd("fd_a", n);
    step();
    wait_fd("fd_b", n);
    chk("fd_period", 32'(n + 1), 32'd16);

    // Leading-zero blanking.
    set_blank(1'b1);
    load_pulse(16'h0007, 4'b0000);
    wait_fd("fd_0007", n);
    chk("lz7_d0", 32'(bus_a.seg), 32'b1110000);
    wait_digit(1, "lz7_sel1");
    chk("lz7_d1", 32'(bus_a.seg), 32'b0000000);
    wait_digit(2, "lz7_sel2");
    chk("lz7_d2", 32'(bus_a.seg), 32'b0000000);
    wait_digit(3, "lz7_sel3");
    chk("lz7_d3", 32'(bus_a.seg), 32'b0000000);
    load_pulse(16'h0000, 4'b0000);
    wait_fd("fd_0000", n);
    chk("lz0_d0", 32'(bus_a.seg), 32'b1111110);
    wait_digit(1, "lz0_sel1");
    chk("lz0_d1", 32'(bus_a.seg), 32'b0000000);
    load_pulse(16'h0400, 4'b0000);
    wait_fd("fd_0400", n);
    chk("lz4_d0", 32'(bus_a.seg), 32'b1111110);
    wait_digit(1, "lz4_sel1");
    chk("lz4_d1", 32'(bus_a.seg), 32'b1111110);
    wait_digit(2, "lz4_sel2");
    chk("lz4_d2", 32'(bus_a.seg), 32'b0110011);
    wait_digit(3, "lz4_sel3");
    chk("lz4_d3", 32'(bus_a.seg), 32'b0000000);

    // Double buffering: mid-frame loads wait for the wrap, last load wins.
    set_blank(1'b0);
    wait_fd("fd_pre_buf", n);
    load_pulse(16'h1111, 4'b0000);
    wait_digit(1, "buf_sel1");
    chk("buf_hold_d1", 32'(bus_a.seg), 32'b1111110);
    wait_digit(2, "buf_sel2");
    chk("buf_hold_d2", 32'(bus_a.seg), 32'b0110011);
    load_pulse(16'h2222, 4'b0000);
    wait_fd("fd_2222", n);
    chk("buf_2222_d0", 32'(bus_a.seg), 32'b1101101);
    wait_digit(3, "buf_sel3");
    chk("buf_2222_d3", 32'(bus_a.seg), 32'b1101101);
    step(); step(); step();
    drive(1'b1, 16'h3333, 4'b0000);
    step();
    drive(1'b0, 16'h0000, 4'b0000);
    chk("wrap_load_fd",  32'(bus_a.frame_done), 32'd1);
    chk("wrap_load_sel", 32'(bus_a.digit_sel), 32'b0001);
    chk("wrap_load_seg", 32'(bus_a.seg), 32'b1111001);

    // Hex decode and active-low select on dut_b.
    load_pulse(16'h000A, 4'b0000);
    wait_fd("fd_000A", n);
    chk("hexA_dec", 32'(bus_a.seg), 32'b0000000);
    chk("hexA_hex", 32'(bus_b.seg), 32'b1110111);
    chk("hexA_selb", 32'(bus_b.digit_sel), 32'b1110);
    wait_digit(1, "hexA_sel1");
    chk("hexA_d1b", 32'(bus_b.seg), 32'b1111110);
    chk("hexA_sel1b", 32'(bus_b.digit_sel), 32'b1101);
    load_pulse(16'hFEDC, 4'b0000);
    wait_fd("fd_FEDC", n);
    chk("hexC", 32'(bus_b.seg), 32'b1001110);
    wait_digit(1, "hex_sel1");
    chk("hexD", 32'(bus_b.seg), 32'b0111101);
    wait_digit(2, "hex_sel2");
    chk("hexE", 32'(bus_b.seg), 32'b1001111);
    wait_digit(3, "hex_sel3");
    chk("hexF", 32'(bus_b.seg), 32'b1000111);
    chk("hexF_dec", 32'(bus_a.seg), 32'b0000000);

`ifdef SEG7_SCAN_DP_EN
    set_blank(1'b1);
    load_pulse(16'h0000, 4'b0010);
    wait_fd("fd_dp", n);
    chk("dp_d0", 32'(bus_a.dp), 32'd0);
    wait_digit(1, "dp_sel1");
    chk("dp_d1", 32'(bus_a.dp), 32'd1);
    chk("dp_d1_blank", 32'(bus_a.seg), 32'b0000000);
    wait_digit(2, "dp_sel2");
    chk("dp_d2", 32'(bus_a.dp), 32'd0);
    set_blank(1'b0);
`endif

    // Reset mid-scan discards the pending load.
    wait_fd("fd_pre_rst", n);
    wait_digit(1, "pre_rst_sel1");
    load_pulse(16'h5555, 4'b1111);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", 32'(bus_a.seg), 32'h00);
    chk("mid_rst_sel", 32'(bus_a.digit_sel), 32'h0);
    chk("mid_rst_fd",  32'(bus_a.frame_done), 32'd0);
`ifdef SEG7_SCAN_DP_EN
    chk("mid_rst_dp",  32'(bus_a.dp), 32'd0);
`endif
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("rst2_no_tick", 32'(bus_a.digit_sel), 32'h0);
    step();
    chk("rst2_tick_sel", 32'(bus_a.digit_sel), 32'b0010);
    wait_fd("fd_post_rst", n);
    chk("rst2_d0", 32'(bus_a.seg), 32'b1111110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment display driver. It accepts a packed vector of 4-bit digit codes through a load strobe and double-buffers them. It then scans one digit per refresh tick, driving shared segment lines plus a one-hot digit select. It sits between datapath result registers and the board display pins, and replaces per-digit combinational decoding.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (>=1).
REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
HEX_MODE, 0, 0: codes 10-15 blank; 1: codes 10-15 show A,b,C,d,E,F.
DIGIT_ACTIVE_LOW, 0, 1 inverts digit_sel polarity (selected digit = 0).

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
load  input  1  capture digits_in this cycle
digits_in  input  4*NUM_DIGITS  digit codes; [3:0] = digit 0 (least significant, rightmost)
blank_lz  input  1  1 = blank leading zeros (sampled live)
seg  output  7  segments a..g, seg[6]=a, seg[0]=g, active-high, registered
digit_sel  output  NUM_DIGITS  one-hot digit enable, registered
frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (async assert, sync-to-clk release is the system's job):
  - seg=0000000, digit_sel=all inactive, frame_done=0.
  - Prescaler=0, index=0, shadow=0, active=0, pending=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1. tick=1 in the cycle count==REFRESH_DIV-1; count then returns to 0.
- Scan index:
  - On tick, index increments. At NUM_DIGITS-1 it wraps to 0.
  - wrap = tick && index==NUM_DIGITS-1.
- Input capture:
  - load=1: shadow<=digits_in, pending<=1. Repeated loads overwrite shadow (last wins).
  - On wrap: active<=digits_in if load, else shadow if pending, else unchanged. pending<=0.
  - Display content therefore changes only at frame boundaries (no tearing).
  - Load coinciding with wrap takes effect in the frame that starts next.
- Output update, registered one cycle after tick:
  - digit_sel <= one-hot of new index, inverted if DIGIT_ACTIVE_LOW.
  - seg <= decode(active digit[new index]).
  - frame_done=1 in the cycle after wrap.
  - Between ticks, outputs hold.
- Decode patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - HEX_MODE=0: codes 10-15 give 0000000.
- Leading-zero blanking (blank_lz=1):
  - Digit k shows 0000000 if its code and all codes of digits >k are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - digit_sel is still driven for blanked digits.
- Scan start after reset:
  - The first tick occurs REFRESH_DIV cycles after reset release.
  - Index moves 0->1, so digit 1 is the first displayed.
  - Scan continues 1,2,...,N-1,0. Constant order thereafter.
- NUM_DIGITS=1: every tick is a wrap; frame_done pulses each slot.
- Reset mid-scan: immediate clear to reset values. Pending load is discarded.

Optional Feature:
- Macro SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_in [NUM_DIGITS] and output dp [1], active-high.
  - dp_in is captured and double-buffered with digits_in under identical load/wrap rules.
  - dp is registered alongside seg. It is not affected by leading-zero blanking. Reset value 0.
- Undefined: ports absent. No decimal-point logic.

Decomposition:
- Package seg7_pkg:
  - Segment pattern constants for 0-F and SEG_BLANK.
  - Typedef for a 7-bit segment vector.
  - Typedef for a 4-bit digit code.
- One combinational sub-module, seg7_hex_decoder (code + hex_mode -> seg), instantiated once on the selected digit.
- Prescaler, index, buffering and blanking logic stay in the top module.

Test Plan:
1. Reset mid-operation with NUM_DIGITS=4, REFRESH_DIV=4 -> seg=0000000, digit_sel=0000, frame_done=0 immediately; first tick 4 cycles after release.
2. Load 0x1234 then wait past the wrap -> next frame shows digit0=0110011/0001, digit1=1111001/0010, digit2=1101101/0100, digit3=0110000/1000; frame_done pulses once per 16 cycles.
3. blank_lz=1 with 0x0007 -> digits 3..1 seg=0000000, digit0=1110000. With 0x0000 -> digit0=1111110. With 0x0400 -> digit3 blank, digit2=0110011, digit1=1111110, digit0=1111110.
4. Code 0xA, HEX_MODE=0 -> 0000000; HEX_MODE=1 -> 1110111. DIGIT_ACTIVE_LOW=1 -> digit_sel for digit0 = 1110.
5. Load 0x1111 mid-frame then load 0x2222 before wrap -> display changes only at wrap and shows 2222. Load 0x3333 in the wrap cycle -> 3333 is shown in the frame that starts next.
6. SEG7_SCAN_DP_EN defined, dp_in=0010 loaded -> dp=1 only while digit_sel=0010, including when that digit is blanked.
